// File: rtl/pwm_blk_gen.sv
// pwm_blk_gen: prescaled PWM generator steered onto one of four digit outputs.
//   S_AXI_ACLK          system clock, all logic on rising edge
//   Local_Reset         synchronous active-high reset
//   pwm_clk_div         prescaler divide value, 0 disables the block
//   pwm_blk_duty_cycle  high-time in ticks per period
//   char_select         digit index receiving the PWM waveform
//   enable              0 forces all digit_out low
//   pwm_clk_counter     ticks since leaving DISABLED (wraps at 2^32)
//   pwm_blk_clk_out     toggles on every tick
//   pwm_out             raw PWM waveform (decoded from registered state)
//   digit_out           one-hot steered PWM
//   period_done         one-cycle pulse after the period wrap tick
module pwm_blk_gen #(
  parameter int unsigned PERIOD_STEPS = 256,
  parameter int unsigned STEP_W       = 16
) (
  input  logic        S_AXI_ACLK,
  input  logic        Local_Reset,
  input  logic [31:0] pwm_clk_div,
  input  logic [31:0] pwm_blk_duty_cycle,
  input  logic [1:0]  char_select,
  input  logic        enable,
  output logic [31:0] pwm_clk_counter,
  output logic        pwm_blk_clk_out,
  output logic        pwm_out,
  output logic [3:0]  digit_out,
  output logic        period_done
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PERIOD_STEPS - 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_START,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       pre_cnt;
  logic [31:0]       div_s;
  logic [31:0]       duty_s;
  logic [STEP_W-1:0] step;
  logic              tick;
  logic              wrap;

  assign tick = (state == ST_RUN) && (pre_cnt == (div_s - 32'd1));
  assign wrap = tick && (step == LAST_STEP);

  // State register
  always_ff @(posedge S_AXI_ACLK) begin
    if (Local_Reset) state <= ST_DISABLED;
    else             state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISABLED: if (pwm_clk_div != 32'd0) state_nxt = ST_START;
      ST_START:    state_nxt = ST_RUN;
      ST_RUN:      if (pwm_clk_div == 32'd0) state_nxt = ST_DISABLED;
      default:     state_nxt = ST_DISABLED;
    endcase
  end

  // Prescaler, step counter, tick counter and shadow registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (Local_Reset) begin
      pre_cnt         <= '0;
      step            <= '0;
      pwm_clk_counter <= '0;
      div_s           <= '0;
      duty_s          <= '0;
      pwm_blk_clk_out <= 1'b0;
      period_done     <= 1'b0;
    end else begin
      period_done <= wrap;
      case (state)
        ST_START: begin
          div_s           <= pwm_clk_div;
          duty_s          <= pwm_blk_duty_cycle;
          pre_cnt         <= '0;
          step            <= '0;
          pwm_clk_counter <= '0;
          pwm_blk_clk_out <= 1'b0;
        end
        ST_RUN: begin
          if (tick) begin
            pre_cnt         <= '0;
            step            <= wrap ? '0 : step + STEP_W'(1);
            pwm_blk_clk_out <= ~pwm_blk_clk_out;
            pwm_clk_counter <= pwm_clk_counter + 32'd1;
          end else begin
            pre_cnt <= pre_cnt + 32'd1;
          end
          // Shadow reload only at a period boundary keeps periods glitch-free
          if (wrap) begin
            div_s  <= pwm_clk_div;
            duty_s <= pwm_blk_duty_cycle;
          end
          // Leaving RUN: wrap reload and pulse above still take effect
          if (pwm_clk_div == 32'd0) begin
            pre_cnt         <= '0;
            step            <= '0;
            pwm_clk_counter <= '0;
            pwm_blk_clk_out <= 1'b0;
          end
        end
        default: begin
          pre_cnt         <= '0;
          step            <= '0;
          pwm_clk_counter <= '0;
          pwm_blk_clk_out <= 1'b0;
        end
      endcase
    end
  end

  // Saturating compare: any duty >= PERIOD_STEPS stays high all period
  assign pwm_out = (state == ST_RUN) && (32'(step) < duty_s);

  // Steering follows live char_select with no shadowing
  always_comb begin
    digit_out = 4'b0000;
    if (enable && pwm_out) digit_out[char_select] = 1'b1;
  end

endmodule

// File: tb/tb_pwm_blk_gen.sv
// Directed self-checking bench for pwm_blk_gen with PERIOD_STEPS=8.
module tb_pwm_blk_gen;

  logic        clk;
  logic        rst;
  logic [31:0] div;
  logic [31:0] duty;
  logic [1:0]  cs;
  logic        en;
  logic [31:0] cnt;
  logic        clk_out;
  logic        pwm;
  logic [3:0]  digit;
  logic        pd;

  int total = 0;
  int bad   = 0;

  pwm_blk_gen #(.PERIOD_STEPS(8), .STEP_W(4)) dut (
    .S_AXI_ACLK         (clk),
    .Local_Reset        (rst),
    .pwm_clk_div        (div),
    .pwm_blk_duty_cycle (duty),
    .char_select        (cs),
    .enable             (en),
    .pwm_clk_counter    (cnt),
    .pwm_blk_clk_out    (clk_out),
    .pwm_out            (pwm),
    .digit_out          (digit),
    .period_done        (pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until period_done is seen, bounded
  task automatic wait_pd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (pd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pwm"}, 32'(pwm), 32'd0);
    chk({tag, "_digit"}, 32'(digit), 32'd0);
    chk({tag, "_cnt"}, cnt, 32'd0);
    chk({tag, "_clkout"}, 32'(clk_out), 32'd0);
    chk({tag, "_pd"}, 32'(pd), 32'd0);
  endtask

  initial begin
    int hi_a;
    int hi_b;
    rst  = 1'b1;
    div  = 32'd0;
    duty = 32'd0;
    cs   = 2'd0;
    en   = 1'b0;
    tick();
    tick();
    chk_idle("reset");

    // div=1 duty=3 char 2: DISABLED -> START -> RUN
    rst  = 1'b0;
    div  = 32'd1;
    duty = 32'd3;
    cs   = 2'd2;
    en   = 1'b1;
    tick();
    chk("start_pwm", 32'(pwm), 32'd0);
    chk("start_cnt", cnt, 32'd0);
    tick();
    for (int k = 0; k <= 16; k++) begin
      chk("p1_pwm", 32'(pwm), 32'((k % 8) < 3));
      chk("p1_digit", 32'(digit), ((k % 8) < 3) ? 32'h4 : 32'h0);
      chk("p1_pd", 32'(pd), 32'((k % 8 == 0) && (k > 0)));
      chk("p1_cnt", cnt, 32'(k));
      chk("p1_clkout", 32'(clk_out), 32'(k % 2));
      if (k < 16) tick();
    end

    // div=4 duty=0, then duty=8, then duty=100; each applies at a wrap
    div  = 32'd4;
    duty = 32'd0;
    wait_pd("p2_sync");
    for (int j = 0; j < 72; j++) begin
      chk("p2_pwm", 32'(pwm), 32'(j >= 32));
      chk("p2_clkout", 32'(clk_out), 32'((j / 4) % 2));
      chk("p2_pd", 32'(pd), 32'(j % 32 == 0));
      chk("p2_cnt", cnt, 32'(24 + j / 4));
      if (j == 1)  duty = 32'd8;
      if (j == 33) duty = 32'd100;
      tick();
    end

    // duty 3 -> 6 mid-period only takes effect after the wrap
    div  = 32'd1;
    duty = 32'd3;
    wait_pd("p3_sync");
    hi_a = 0;
    hi_b = 0;
    for (int m = 0; m < 16; m++) begin
      chk("p3_pwm", 32'(pwm), (m < 8) ? 32'(m < 3) : 32'((m - 8) < 6));
      chk("p3_pd", 32'(pd), 32'((m == 0) || (m == 8)));
      if (pwm === 1'b1) begin
        if (m < 8) hi_a++;
        else       hi_b++;
      end
      if (m == 1) duty = 32'd6;
      tick();
    end
    chk("p3_hi_old", 32'(hi_a), 32'd3);
    chk("p3_hi_new", 32'(hi_b), 32'd6);

    // div=2 running, then div=0 disables on the next edge
    div = 32'd2;
    wait_pd("p4_sync");
    tick();
    tick();
    tick();
    div = 32'd0;
    tick();
    chk_idle("p4_off");
    tick();
    chk("p4_off2_cnt", cnt, 32'd0);
    div = 32'd2;
    tick();
    chk("p4_start_pwm", 32'(pwm), 32'd0);
    chk("p4_start_cnt", cnt, 32'd0);
    tick();
    chk("p4_run_pwm", 32'(pwm), 32'd1);
    chk("p4_run_digit", 32'(digit), 32'h4);
    chk("p4_run_cnt", cnt, 32'd0);
    tick();
    tick();
    chk("p4_cnt1", cnt, 32'd1);
    chk("p4_clkout1", 32'(clk_out), 32'd1);
    tick();
    tick();
    chk("p4_cnt2", cnt, 32'd2);
    chk("p4_pwm2", 32'(pwm), 32'd1);

    // Re-steer on the same cycle, then mask with enable
    cs = 2'd0;
    #1;
    chk("p5_digit0", 32'(digit), 32'h1);
    cs = 2'd3;
    #1;
    chk("p5_digit3", 32'(digit), 32'h8);
    en = 1'b0;
    #1;
    chk("p5_dis_digit", 32'(digit), 32'h0);
    chk("p5_dis_pwm", 32'(pwm), 32'd1);
    hi_a = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      chk("p5_mask_digit", 32'(digit), 32'h0);
      if (pwm === 1'b1) hi_a++;
    end
    chk("p5_hi_count", 32'(hi_a), 32'd12);

    // One-cycle reset mid-period, then restart through START
    en  = 1'b1;
    rst = 1'b1;
    tick();
    chk_idle("p6_rst");
    rst = 1'b0;
    tick();
    chk("p6_start_pwm", 32'(pwm), 32'd0);
    chk("p6_start_cnt", cnt, 32'd0);
    tick();
    chk("p6_run_pwm", 32'(pwm), 32'd1);
    chk("p6_run_digit", 32'(digit), 32'h8);
    chk("p6_run_cnt", cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
